// File: rtl/width_16to8.sv
// width_16to8: unpacks 16-bit words into a registered byte stream.
// Words land in a small circular buffer; a three-state FSM pulls one word
// at a time, presents its first byte, then the byte held back from it.
module width_16to8 #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] data_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [7:0]  data_out,
    input  logic        ready_in,
    output logic        busy
);

    localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [15:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [15:0]      head_word;
    logic [7:0]       first_byte;
    logic [7:0]       second_byte;
    logic [7:0]       hold;
    logic [7:0]       hold_n;
    logic [7:0]       data_out_n;
    logic             valid_out_n;

    // Readiness comes from the registered count only, so a full buffer
    // refuses a word even in a cycle where the FSM pops one.
    assign ready_out   = (count != FULL_CNT);
    assign push        = valid_in && ready_out;
    assign head_word   = mem[rd_ptr];
    assign first_byte  = MSB_FIRST ? head_word[15:8] : head_word[7:0];
    assign second_byte = MSB_FIRST ? head_word[7:0]  : head_word[15:8];
    assign busy        = (state != IDLE) || (count != '0);

    // Word storage; pointers are cleared on reset, so stale entries are dead
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Circular buffer pointers and occupancy, wrapping at BUF_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage registers: FSM state, presented byte and the held-back byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data_out  <= 8'h00;
            hold      <= 8'h00;
        end else begin
            state     <= state_n;
            valid_out <= valid_out_n;
            data_out  <= data_out_n;
            hold      <= hold_n;
        end
    end

    // Next-state logic: load a word's first byte, then its second, then
    // either chain straight into the next buffered word or go idle.
    always_comb begin
        state_n     = state;
        valid_out_n = valid_out;
        data_out_n  = data_out;
        hold_n      = hold;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    data_out_n  = first_byte;
                    hold_n      = second_byte;
                    valid_out_n = 1'b1;
                    state_n     = FIRST;
                end
            end
            FIRST: begin
                if (ready_in) begin
                    data_out_n = hold;
                    state_n    = SECOND;
                end
            end
            SECOND: begin
                if (ready_in) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        data_out_n = first_byte;
                        hold_n     = second_byte;
                        state_n    = FIRST;
                    end else begin
                        valid_out_n = 1'b0;
                        state_n     = IDLE;
                    end
                end
            end
            default: begin
                valid_out_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_width_16to8.sv
// tb_width_16to8: directed scenarios plus randomized traffic checked
// against a byte-queue reference model, on two parameterisations.
module tb_width_16to8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [15:0] data_in = 16'h0000;

    logic        a_valid_in, b_valid_in;
    logic        a_ready_out, b_ready_out;
    logic        a_valid_out, b_valid_out;
    logic [7:0]  a_data_out, b_data_out;
    logic        a_busy, b_busy;

    logic        cur_ready_out, cur_valid_out, cur_busy;
    logic [7:0]  cur_data_out;

    int errors = 0;
    int checks = 0;

    assign a_valid_in    = valid_in & ~sel;
    assign b_valid_in    = valid_in & sel;
    assign cur_ready_out = sel ? b_ready_out : a_ready_out;
    assign cur_valid_out = sel ? b_valid_out : a_valid_out;
    assign cur_data_out  = sel ? b_data_out  : a_data_out;
    assign cur_busy      = sel ? b_busy      : a_busy;

    width_16to8 #(.MSB_FIRST(1'b1), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(a_valid_in), .data_in(data_in),
        .ready_out(a_ready_out), .valid_out(a_valid_out), .data_out(a_data_out),
        .ready_in(ready_in), .busy(a_busy)
    );

    width_16to8 #(.MSB_FIRST(1'b0), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .data_in(data_in),
        .ready_out(b_ready_out), .valid_out(b_valid_out), .data_out(b_data_out),
        .ready_in(ready_in), .busy(b_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = 16'h0000;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        valid_in = 1'b1;
        data_in  = 16'h1122;
        ready_in = 1'b0;
        rst_n    = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        checks++;
        if (cur_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", cur_valid_out);
        end
        checks++;
        if (cur_data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 00", cur_data_out);
        end
        checks++;
        if (cur_ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cur_ready_out);
        end
        checks++;
        if (cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", cur_busy);
        end
        do_reset();
    endtask

    task automatic test_single_word;
        sel = 1'b0;
        do_reset();
        valid_in = 1'b1;
        data_in  = 16'hA55A;
        ready_in = 1'b1;
        checks++;
        if (cur_ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b expected 1", cur_ready_out);
        end
        step();
        valid_in = 1'b0;
        checks++;
        if (cur_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_nobypass: valid_out=%b expected 0", cur_valid_out);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_first: got v=%b d=%h expected v=1 d=a5", cur_valid_out, cur_data_out);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL single_second: got v=%b d=%h expected v=1 d=5a", cur_valid_out, cur_data_out);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b0 || cur_data_out !== 8'h5A || cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_end: got v=%b d=%h busy=%b expected v=0 d=5a busy=0",
                     cur_valid_out, cur_data_out, cur_busy);
        end
    endtask

    task automatic test_backpressure;
        sel = 1'b0;
        do_reset();
        valid_in = 1'b1;
        data_in  = 16'hA55A;
        ready_in = 1'b0;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cur_valid_out !== 1'b1 || cur_data_out !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d: got v=%b d=%h expected v=1 d=a5", i, cur_valid_out, cur_data_out);
            end
        end
        ready_in = 1'b1;
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL bp_second: got v=%b d=%h expected v=1 d=5a", cur_valid_out, cur_data_out);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_end: got v=%b expected 0", cur_valid_out);
        end
    endtask

    task automatic test_streaming;
        logic [15:0] words [3];
        logic [7:0]  exp [8];
        logic        exp_v [8];
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        exp   = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hBC};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        sel = 1'b0;
        do_reset();
        ready_in = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (t < 3) begin
                valid_in = 1'b1;
                data_in  = words[t];
                checks++;
                if (cur_ready_out !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stream_ready%0d: got %b expected 1", t, cur_ready_out);
                end
            end else begin
                valid_in = 1'b0;
            end
            step();
            checks++;
            if (cur_valid_out !== exp_v[t] || (exp_v[t] && cur_data_out !== exp[t])) begin
                errors++;
                $display("[TB] FAIL stream_edge%0d: got v=%b d=%h expected v=%b d=%h",
                         t, cur_valid_out, cur_data_out, exp_v[t], exp[t]);
            end
        end
    endtask

    task automatic test_full;
        logic [15:0] words [4];
        logic [7:0]  exp [8];
        int          got;
        logic        acc;
        words = '{16'hC0C1, 16'hC2C3, 16'hC4C5, 16'hC6C7};
        exp   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        got = 0;
        acc = 1'b0;
        sel = 1'b0;
        do_reset();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = words[i];
            checks++;
            if (cur_ready_out !== (i < 3 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL full_ready%0d: got %b expected %b", i, cur_ready_out, (i < 3));
            end
            if (i < 3) step();
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cur_ready_out !== 1'b0 || cur_valid_out !== 1'b1 || cur_data_out !== 8'hC0 || cur_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL full_hold%0d: got rdy=%b v=%b d=%h busy=%b expected rdy=0 v=1 d=c0 busy=1",
                         i, cur_ready_out, cur_valid_out, cur_data_out, cur_busy);
            end
        end
        ready_in = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (cur_valid_out && ready_in) begin
                checks++;
                if (cur_data_out !== exp[got]) begin
                    errors++;
                    $display("[TB] FAIL full_byte%0d: got %h expected %h", got, cur_data_out, exp[got]);
                end
                got++;
            end
            if (valid_in && cur_ready_out) acc = 1'b1;
            @(posedge clk);
            #1;
            if (acc) valid_in = 1'b0;
        end
        checks++;
        if (got != 8 || acc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_drain: got %0d bytes accepted4=%b expected 8 bytes accepted4=1", got, acc);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b0 || cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_idle: got v=%b busy=%b expected 0 0", cur_valid_out, cur_busy);
        end
    endtask

    task automatic test_reset_mid(input logic which);
        logic [7:0] first_exp;
        logic [7:0] second_exp;
        logic [7:0] mid_exp;
        first_exp  = which ? 8'hEF : 8'hBE;
        second_exp = which ? 8'hBE : 8'hEF;
        mid_exp    = which ? 8'h13 : 8'h57;
        sel = which;
        do_reset();
        ready_in = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'h1357;
        step();
        data_in  = 16'h2468;
        step();
        valid_in = 1'b0;
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== mid_exp) begin
            errors++;
            $display("[TB] FAIL rmid%0d_second: got v=%b d=%h expected v=1 d=%h", which, cur_valid_out, cur_data_out, mid_exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cur_valid_out !== 1'b0 || cur_data_out !== 8'h00 || cur_ready_out !== 1'b1 || cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid%0d_async: got v=%b d=%h rdy=%b busy=%b expected v=0 d=00 rdy=1 busy=0",
                     which, cur_valid_out, cur_data_out, cur_ready_out, cur_busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'hBEEF;
        step();
        valid_in = 1'b0;
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== first_exp) begin
            errors++;
            $display("[TB] FAIL rmid%0d_first: got v=%b d=%h expected v=1 d=%h", which, cur_valid_out, cur_data_out, first_exp);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b1 || cur_data_out !== second_exp) begin
            errors++;
            $display("[TB] FAIL rmid%0d_next: got v=%b d=%h expected v=1 d=%h", which, cur_valid_out, cur_data_out, second_exp);
        end
        step();
        checks++;
        if (cur_valid_out !== 1'b0 || cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid%0d_end: got v=%b busy=%b expected 0 0", which, cur_valid_out, cur_busy);
        end
    endtask

    task automatic test_random(input logic which, input int cycles);
        logic [7:0] exp_q [$];
        logic [7:0] exp_b;
        logic       hold_pending;
        logic [7:0] held;
        logic       waiting;
        logic       msb;
        int         words;
        hold_pending = 1'b0;
        held    = 8'h00;
        waiting = 1'b0;
        words   = 0;
        msb     = ~which;
        sel = which;
        do_reset();
        for (int c = 0; c < cycles + 60; c++) begin
            @(negedge clk);
            if (hold_pending) begin
                checks++;
                if (cur_valid_out !== 1'b1 || cur_data_out !== held) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_stable: got v=%b d=%h expected v=1 d=%h", which, cur_valid_out, cur_data_out, held);
                end
            end
            if (!waiting) begin
                if (c < cycles) begin
                    valid_in = ($urandom_range(0, 99) < 55);
                    data_in  = 16'($urandom);
                end else begin
                    valid_in = 1'b0;
                end
            end
            ready_in = (c >= cycles) ? 1'b1 : ($urandom_range(0, 99) < 60);
            if (cur_valid_out && ready_in) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_extra: got byte %h expected none", which, cur_data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (cur_data_out !== exp_b) begin
                        errors++;
                        $display("[TB] FAIL rnd%0d_byte: got %h expected %h", which, cur_data_out, exp_b);
                    end
                end
            end
            if (valid_in && cur_ready_out) begin
                if (msb) begin
                    exp_q.push_back(data_in[15:8]);
                    exp_q.push_back(data_in[7:0]);
                end else begin
                    exp_q.push_back(data_in[7:0]);
                    exp_q.push_back(data_in[15:8]);
                end
                words++;
                waiting = 1'b0;
            end else begin
                waiting = valid_in;
            end
            hold_pending = cur_valid_out && !ready_in;
            held = cur_data_out;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || cur_valid_out !== 1'b0 || cur_busy !== 1'b0 || words == 0) begin
            errors++;
            $display("[TB] FAIL rnd%0d_drain: got left=%0d v=%b busy=%b words=%0d expected left=0 v=0 busy=0 words>0",
                     which, exp_q.size(), cur_valid_out, cur_busy, words);
        end
        valid_in = 1'b0;
        ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_streaming();
        test_full();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
